// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle saturating ALU units (add and subtract).
// Holds default widths, the two-state FSM encoding, saturation limits and the flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_DIGIT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ALU_WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [ALU_WIDTH-1:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic zr;
    logic neg;
    logic ov;
  } alu_flags_t;

endpackage

// File: rtl/sat_add_digit.sv
// DIGIT-bit combinational ripple adder slice; the top reuses one instance for every step.
module sat_add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_s,
  output logic             o_cout
);

  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};

endmodule

// File: rtl/sat_add_seq.sv
// Multi-cycle saturating two's-complement adder: DIGIT bits per cycle through a registered carry,
// with zr/neg/ov flags registered together with the result on the done edge.
module sat_add_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DIGIT = ALU_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             neg,
  output logic             ov,
  output state_t           dbg_state
);

  // Handshake: start is sampled only in IDLE (busy==0); done is a one-cycle pulse and out/flags
  // stay valid from that cycle until the next done. There is no backpressure on the result.

  localparam int STEPS  = WIDTH / DIGIT;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [WIDTH-1:0]  W_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  W_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_part;
  logic [WIDTH-1:0]  r_out;
  alu_flags_t        r_flags;
  logic              r_done;

  logic [DIGIT-1:0]  w_dig_a;
  logic [DIGIT-1:0]  w_dig_b;
  logic [DIGIT-1:0]  w_dig_s;
  logic              w_dig_cout;
  logic              w_last;
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  w_res;
  alu_flags_t        w_res_flags;

  assign w_dig_a = r_a[r_step*DIGIT +: DIGIT];
  assign w_dig_b = r_b[r_step*DIGIT +: DIGIT];
  assign w_last  = (r_step == LAST_STEP);

  sat_add_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a    (w_dig_a),
    .i_b    (w_dig_b),
    .i_cin  (r_carry),
    .o_s    (w_dig_s),
    .o_cout (w_dig_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Full sum as it will stand after this step; only meaningful on the last step, where the
  // MSB digit's carry-out is simply dropped.
  always_comb begin
    w_sum = r_part;
    w_sum[r_step*DIGIT +: DIGIT] = w_dig_s;
    w_res       = w_sum;
    w_res_flags = '{zr: ~|w_sum, neg: w_sum[WIDTH-1], ov: 1'b0};
    if (!r_a[WIDTH-1] && !r_b[WIDTH-1] && w_sum[WIDTH-1]) begin
      w_res       = W_SAT_POS;
      w_res_flags = '{zr: 1'b0, neg: 1'b0, ov: 1'b1};
    end else if (r_a[WIDTH-1] && r_b[WIDTH-1] && !w_sum[WIDTH-1]) begin
      w_res       = W_SAT_NEG;
      w_res_flags = '{zr: 1'b0, neg: 1'b1, ov: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step  <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_out   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= in1;
            r_b     <= in2;
            r_carry <= 1'b0;
            r_step  <= '0;
          end
        end
        RUN: begin
          r_part  <= w_sum;
          r_carry <= w_dig_cout;
          r_step  <= r_step + 1'b1;
          if (w_last) begin
            r_out   <= w_res;
            r_flags <= w_res_flags;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = r_done;
  assign out       = r_out;
  assign zr        = r_flags.zr;
  assign neg       = r_flags.neg;
  assign ov        = r_flags.ov;
  assign dbg_state = r_state;

endmodule
